// File: rtl/cpu_types_pkg.sv
// Shared CPU memory types: data word, RAM status and memory-arbiter FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } memarb_state_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath request/response bundle plus shared RAM port; slave = arbiter view, master = requester/RAM view.
// mem_err is present only when MEMARB_TIMEOUT_EN is defined.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
`ifdef MEMARB_TIMEOUT_EN
  logic      mem_err;
`endif

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
`ifdef MEMARB_TIMEOUT_EN
    output mem_err,
`endif
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
`ifdef MEMARB_TIMEOUT_EN
    input  mem_err,
`endif
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memarb_timeout.sv
// Grant-age counter: counts cycles while a grant is active, clears when idle.
// Latency: expired is combinational from the registered count; no backpressure.
module memarb_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = active && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter: data over instruction, hit returned as a one-cycle wait-low; optional grant timeout (MEMARB_TIMEOUT_EN).
// Latency: grant one cycle after request, hit combinational on ramstate==ACCESS; requester is held off via iwait/dwait.
module memory_arbiter
`ifdef MEMARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = 64
)
`endif
(
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);
  import cpu_types_pkg::*;

  memarb_state_t state, state_nxt;
  logic          timeout;
  logic          iwait_c, dwait_c, ren_c, wen_c;
  word_t         iload_c, dload_c, addr_c, store_c;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  memarb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst_n   (nRST),
    .active  (state != IDLE),
    .expired (timeout)
  );
  // A wait-low without ACCESS can only come from the timeout abort.
  assign bus.mem_err = (!iwait_c || !dwait_c) && (bus.ramstate != ACCESS);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    iwait_c   = 1'b1;
    dwait_c   = 1'b1;
    iload_c   = '0;
    dload_c   = '0;
    ren_c     = 1'b0;
    wen_c     = 1'b0;
    addr_c    = '0;
    store_c   = '0;
    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_nxt = DGNT;
        end else if (bus.iREN) begin
          state_nxt = IGNT;
        end
      end
      DGNT: begin
        if (!(bus.dREN || bus.dWEN)) begin
          state_nxt = IDLE;
        end else begin
          addr_c  = bus.daddr;
          store_c = bus.dstore;
          wen_c   = bus.dWEN;
          ren_c   = !bus.dWEN;
          if (bus.ramstate == ACCESS) begin
            dwait_c   = 1'b0;
            dload_c   = bus.dWEN ? '0 : bus.ramload;
            state_nxt = IDLE;
          end else if (timeout) begin
            dwait_c   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      IGNT: begin
        if (!bus.iREN) begin
          state_nxt = IDLE;
        end else begin
          addr_c = bus.iaddr;
          ren_c  = 1'b1;
          if (bus.ramstate == ACCESS) begin
            iwait_c   = 1'b0;
            iload_c   = bus.ramload;
            state_nxt = IDLE;
          end else if (timeout) begin
            iwait_c   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.iwait    = iwait_c;
  assign bus.iload    = iload_c;
  assign bus.dwait    = dwait_c;
  assign bus.dload    = dload_c;
  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;
  assign bus.ramaddr  = addr_c;
  assign bus.ramstore = store_c;
endmodule
